// File: rtl/layer_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// layer_seq_ctrl_if
// Handshake bundle between the transformer-layer sequencer and its
// environment (top model controller plus the seven sub-block engines).
//   ln_start          : pulse from the model controller, run one layer
//   *_done            : sub-block completion pulses (into the sequencer)
//   *_start           : sub-block start pulses (out of the sequencer)
//   attn_head         : head index currently in attention
//   linear2_done      : layer complete pulse
//   busy              : sequencer not idle
//   timeout_err       : stage watchdog expired, layer aborted
// modport master = sequencer side, modport slave = environment side.
// ---------------------------------------------------------------------------
interface layer_seq_ctrl_if #(
  parameter int NUM_HEAD = 12
);
  localparam int HW = (NUM_HEAD > 1) ? $clog2(NUM_HEAD) : 1;

  logic          ln_start;
  logic          ln1_done;
  logic          qkv_done;
  logic          attn_done;
  logic          proj_done;
  logic          ln2_done;
  logic          fc1_done;
  logic          fc2_done;
  logic          ln1_start;
  logic          qkv_start;
  logic          attn_start;
  logic          proj_start;
  logic          ln2_start;
  logic          fc1_start;
  logic          fc2_start;
  logic [HW-1:0] attn_head;
  logic          linear2_done;
  logic          busy;
  logic          timeout_err;

  modport master (
    input  ln_start, ln1_done, qkv_done, attn_done, proj_done,
           ln2_done, fc1_done, fc2_done,
    output ln1_start, qkv_start, attn_start, proj_start, ln2_start,
           fc1_start, fc2_start, attn_head, linear2_done, busy, timeout_err
  );

  modport slave (
    output ln_start, ln1_done, qkv_done, attn_done, proj_done,
           ln2_done, fc1_done, fc2_done,
    input  ln1_start, qkv_start, attn_start, proj_start, ln2_start,
           fc1_start, fc2_start, attn_head, linear2_done, busy, timeout_err
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// layer_seq_ctrl
// Sequences one transformer layer through LN1 -> QKV -> ATTN (NUM_HEAD times)
// -> PROJ -> LN2 -> FC1 -> FC2, issuing one-cycle start pulses and waiting for
// each sub-block's done pulse. A per-stage watchdog aborts the layer if a
// stage takes TIMEOUT cycles without completing.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_if : layer_seq_ctrl_if.master (see interface file for signal list)
// ---------------------------------------------------------------------------
module layer_seq_ctrl #(
  parameter int NUM_HEAD = 12,
  parameter int TIMEOUT  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  layer_seq_ctrl_if.master        bus_if
);

  localparam int HW = (NUM_HEAD > 1) ? $clog2(NUM_HEAD) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] LAST_HEAD = HW'(NUM_HEAD - 1);
  localparam logic [WW-1:0] LAST_WDOG = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LN1  = 3'd1,
    ST_QKV  = 3'd2,
    ST_ATTN = 3'd3,
    ST_PROJ = 3'd4,
    ST_LN2  = 3'd5,
    ST_FC1  = 3'd6,
    ST_FC2  = 3'd7
  } state_t;

  state_t        state_q;
  logic [HW-1:0] head_q;
  logic [WW-1:0] wdog_q;
  logic          ln1_start_q;
  logic          qkv_start_q;
  logic          attn_start_q;
  logic          proj_start_q;
  logic          ln2_start_q;
  logic          fc1_start_q;
  logic          fc2_start_q;
  logic          linear2_done_q;
  logic          timeout_err_q;
  logic          done_s;

  // Only the done input belonging to the current stage is honoured.
  always_comb begin
    done_s = 1'b0;
    case (state_q)
      ST_LN1:  done_s = bus_if.ln1_done;
      ST_QKV:  done_s = bus_if.qkv_done;
      ST_ATTN: done_s = bus_if.attn_done;
      ST_PROJ: done_s = bus_if.proj_done;
      ST_LN2:  done_s = bus_if.ln2_done;
      ST_FC1:  done_s = bus_if.fc1_done;
      ST_FC2:  done_s = bus_if.fc2_done;
      default: done_s = 1'b0;
    endcase
  end

  // Sequencer FSM with watchdog, head counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      head_q         <= '0;
      wdog_q         <= '0;
      ln1_start_q    <= 1'b0;
      qkv_start_q    <= 1'b0;
      attn_start_q   <= 1'b0;
      proj_start_q   <= 1'b0;
      ln2_start_q    <= 1'b0;
      fc1_start_q    <= 1'b0;
      fc2_start_q    <= 1'b0;
      linear2_done_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless a transition below re-asserts them.
      ln1_start_q    <= 1'b0;
      qkv_start_q    <= 1'b0;
      attn_start_q   <= 1'b0;
      proj_start_q   <= 1'b0;
      ln2_start_q    <= 1'b0;
      fc1_start_q    <= 1'b0;
      fc2_start_q    <= 1'b0;
      linear2_done_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wdog_q <= '0;
          if (bus_if.ln_start) begin
            state_q     <= ST_LN1;
            ln1_start_q <= 1'b1;
            head_q      <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          // A done in the expiry cycle wins over the watchdog.
          if (done_s) begin
            wdog_q <= '0;
            case (state_q)
              ST_LN1: begin
                state_q     <= ST_QKV;
                qkv_start_q <= 1'b1;
              end
              ST_QKV: begin
                state_q      <= ST_ATTN;
                attn_start_q <= 1'b1;
              end
              ST_ATTN: begin
                if (head_q == LAST_HEAD) begin
                  head_q       <= '0;
                  state_q      <= ST_PROJ;
                  proj_start_q <= 1'b1;
                end else begin
                  head_q       <= head_q + HW'(1);
                  attn_start_q <= 1'b1;
                end
              end
              ST_PROJ: begin
                state_q     <= ST_LN2;
                ln2_start_q <= 1'b1;
              end
              ST_LN2: begin
                state_q     <= ST_FC1;
                fc1_start_q <= 1'b1;
              end
              ST_FC1: begin
                state_q     <= ST_FC2;
                fc2_start_q <= 1'b1;
              end
              ST_FC2: begin
                state_q        <= ST_IDLE;
                linear2_done_q <= 1'b1;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end else if (wdog_q == LAST_WDOG) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
            head_q        <= '0;
            wdog_q        <= '0;
          end else begin
            // Saturates implicitly: expiry above fires before any wrap.
            wdog_q <= wdog_q + WW'(1);
          end
        end
      endcase
    end
  end

  assign bus_if.ln1_start    = ln1_start_q;
  assign bus_if.qkv_start    = qkv_start_q;
  assign bus_if.attn_start   = attn_start_q;
  assign bus_if.proj_start   = proj_start_q;
  assign bus_if.ln2_start    = ln2_start_q;
  assign bus_if.fc1_start    = fc1_start_q;
  assign bus_if.fc2_start    = fc2_start_q;
  assign bus_if.attn_head    = head_q;
  assign bus_if.linear2_done = linear2_done_q;
  assign bus_if.timeout_err  = timeout_err_q;
  // busy depends on the registered state alone.
  assign bus_if.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_layer_seq_ctrl
// Scoreboard bench for layer_seq_ctrl with NUM_HEAD=2, TIMEOUT=8. Stimulus
// pushes expected (cycle, pulse set, head) entries; a negedge monitor pops and
// compares whenever any pulse output is high. Sub-block dones come from a
// responder with selectable 0- or 1-cycle latency, per-stage enables and
// manual overrides.
// ---------------------------------------------------------------------------
module tb_layer_seq_ctrl;

  localparam int NH = 2;

  // Pulse vector bit positions: {tmo, l2, fc2, fc1, ln2, proj, attn, qkv, ln1}
  localparam logic [8:0] P_LN1  = 9'h001;
  localparam logic [8:0] P_QKV  = 9'h002;
  localparam logic [8:0] P_ATTN = 9'h004;
  localparam logic [8:0] P_PROJ = 9'h008;
  localparam logic [8:0] P_LN2  = 9'h010;
  localparam logic [8:0] P_FC1  = 9'h020;
  localparam logic [8:0] P_FC2  = 9'h040;
  localparam logic [8:0] P_L2   = 9'h080;
  localparam logic [8:0] P_TMO  = 9'h100;

  typedef struct {
    int         cyc;
    logic [8:0] pulses;
    logic [0:0] head;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];

  logic       ln_start_r = 1'b0;
  logic       lat0 = 1'b0;
  logic [6:0] en = 7'h7f;
  logic [6:0] man = 7'h00;
  logic [6:0] start_v;
  logic [6:0] prev_q;
  logic [6:0] done_v;
  logic [8:0] p_s;

  layer_seq_ctrl_if #(.NUM_HEAD(NH)) bus ();

  layer_seq_ctrl #(.NUM_HEAD(NH), .TIMEOUT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign start_v = {bus.fc2_start, bus.fc1_start, bus.ln2_start, bus.proj_start,
                    bus.attn_start, bus.qkv_start, bus.ln1_start};
  assign p_s = {bus.timeout_err, bus.linear2_done, start_v};

  // Responder: done follows start by one cycle, or in the same cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 7'h00;
    else     prev_q <= start_v;
  end

  always_comb begin
    done_v = (((lat0 ? start_v : prev_q) & en) | man);
  end

  assign bus.ln_start  = ln_start_r;
  assign bus.ln1_done  = done_v[0];
  assign bus.qkv_done  = done_v[1];
  assign bus.attn_done = done_v[2];
  assign bus.proj_done = done_v[3];
  assign bus.ln2_done  = done_v[4];
  assign bus.fc1_done  = done_v[5];
  assign bus.fc2_done  = done_v[6];

  // Monitor: every pulse event must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && p_s != 9'h000) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_pulse: cyc=%0d got pulses=%b head=%0d, required none",
                 cyc, p_s, bus.attn_head);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.pulses !== p_s || e.cyc != cyc || e.head !== bus.attn_head) begin
          nerr++;
          $display("FAIL seq: got cyc=%0d pulses=%b head=%0d, required cyc=%0d pulses=%b head=%0d",
                   cyc, p_s, bus.attn_head, e.cyc, e.pulses, e.head);
        end
      end
    end
  end

  task automatic push(input int c, input logic [8:0] p, input logic [0:0] h);
    exp_t e;
    e.cyc = c; e.pulses = p; e.head = h;
    q.push_back(e);
  endtask

  function automatic logic [8:0] seq_pulse(input int k);
    case (k)
      0: return P_LN1;
      1: return P_QKV;
      2: return P_ATTN;
      3: return P_ATTN;
      4: return P_PROJ;
      5: return P_LN2;
      6: return P_FC1;
      7: return P_FC2;
      default: return P_L2;
    endcase
  endfunction

  // Step k of a normal layer appears at c0 + k*step + 1; k=3 is head 1.
  task automatic push_seq(input int c0, input int step, input int last);
    for (int k = 0; k <= last; k++)
      push(c0 + k * step + 1, seq_pulse(k), (k == 3) ? 1'b1 : 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    nvec++;
    if (got !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Drives ln_start in the current cycle and returns that cycle number.
  task automatic go(output int c0);
    @(negedge clk);
    c0 = cyc;
    ln_start_r = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (q.size() == 0 && !bus.busy) break;
      @(negedge clk);
    end
    nvec++;
    if (i == 200) begin
      nerr++;
      $display("FAIL %s_drain: got %0d pending, busy=%0d, required 0 pending, busy=0",
               name, q.size(), bus.busy);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_pulses", 32'(p_s), 32'd0);
    chk("reset_head", 32'(bus.attn_head), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1-cycle done latency; ln_start during FC2 must be ignored.
    lat0 = 1'b0;
    go(c0);
    push_seq(c0, 2, 8);
    @(negedge clk); ln_start_r = 1'b0;
    chk("busy_running", 32'(bus.busy), 32'd1);
    repeat (15) @(negedge clk);
    ln_start_r = 1'b1;
    @(negedge clk); ln_start_r = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    wait_idle("lat1");

    // Zero-latency dones: linear2_done 9 cycles after ln_start.
    lat0 = 1'b1;
    go(c0);
    push_seq(c0, 1, 8);
    @(negedge clk); ln_start_r = 1'b0;
    wait_idle("lat0");
    lat0 = 1'b0;

    // Foreign done and ln_start while in QKV are ignored.
    go(c0);
    push_seq(c0, 2, 8);
    @(negedge clk); ln_start_r = 1'b0;
    repeat (2) @(negedge clk);
    man = 7'b0100000;
    ln_start_r = 1'b1;
    @(negedge clk);
    man = 7'h00;
    ln_start_r = 1'b0;
    wait_idle("ignore");

    // qkv_done never returned: timeout 8 cycles after qkv_start.
    en = 7'b1111101;
    go(c0);
    push(c0 + 1, P_LN1, 1'b0);
    push(c0 + 3, P_QKV, 1'b0);
    push(c0 + 11, P_TMO, 1'b0);
    @(negedge clk); ln_start_r = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_tmo", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("busy_at_tmo", 32'(bus.busy), 32'd0);
    wait_idle("timeout");

    // qkv_done in the expiry cycle: transition wins, no timeout.
    go(c0);
    push(c0 + 1, P_LN1, 1'b0);
    push(c0 + 3, P_QKV, 1'b0);
    for (int k = 2; k <= 8; k++)
      push(c0 + 2 * k + 7, seq_pulse(k), (k == 3) ? 1'b1 : 1'b0);
    @(negedge clk); ln_start_r = 1'b0;
    repeat (9) @(negedge clk);
    man = 7'b0000010;
    @(negedge clk);
    man = 7'h00;
    en = 7'h7f;
    wait_idle("done_wins");

    // Reset while in ATTN with head 1, then a fresh layer.
    go(c0);
    push_seq(c0, 2, 3);
    @(negedge clk); ln_start_r = 1'b0;
    repeat (6) @(negedge clk);
    chk("head_before_rst", 32'(bus.attn_head), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_pulses", 32'(p_s), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_head", 32'(bus.attn_head), 32'd0);
    chk("rst_queue", 32'(q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go(c0);
    push_seq(c0, 2, 8);
    @(negedge clk); ln_start_r = 1'b0;
    wait_idle("after_rst");

    chk("final_queue", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
